// File: rtl/spi_frame_collector_pkg.sv
// Shared constants, types and helpers for the multi-channel SPI frame collector.
package spi_frame_collector_pkg;

  localparam int C_SYNC_STAGES      = 2;
  localparam int C_FRAMES_CNT_WIDTH = 8;

  typedef struct packed {
    logic overflow;
    logic len_err;
  } t_ch_status;

  // Ceiling log2, never below 1 so it can size a counter or pointer directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_frame_collector_ch.sv
// One SPI monitor channel: input synchronisers, deserialiser, LOAD-window
// counters, sticky status and a show-ahead frame FIFO.
module spi_frame_collector_ch
  import spi_frame_collector_pkg::*;
#(
  parameter int G_FRAME_WIDTH = 16,
  parameter int G_FIFO_DEPTH  = 8,
  parameter int G_CPOL        = 0,
  parameter int G_CPHA        = 0,
  parameter int G_MSB_FIRST   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_spi_sclk,
  input  logic                          i_spi_mosi,
  input  logic                          i_spi_load,
  input  logic                          i_pop,
  input  logic                          i_clr_status,
  output logic                          o_frame_received,
  output logic                          o_load_received,
  output logic [G_FRAME_WIDTH-1:0]      o_last_data,
  output logic [C_FRAMES_CNT_WIDTH-1:0] o_frames_in_load,
  output logic                          o_fifo_valid,
  output logic [G_FRAME_WIDTH-1:0]      o_fifo_data,
  output logic                          o_overflow,
  output logic                          o_len_err
);

  localparam int   CNT_W       = clog2(G_FRAME_WIDTH);
  localparam int   AW          = clog2(G_FIFO_DEPTH);
  localparam logic CPOL_L      = (G_CPOL != 0);
  localparam logic SAMPLE_RISE = (G_CPOL == G_CPHA);

  logic [C_SYNC_STAGES-1:0] sclk_sync, mosi_sync, load_sync;
  logic sclk_prev, load_prev;
  logic sclk_s, mosi_s, load_s;
  logic sample_edge, load_fall, load_rise, shift_en, frame_done, len_err_set;

  logic [G_FRAME_WIDTH-1:0]      shift_reg, shift_nxt;
  logic [CNT_W-1:0]              bit_cnt;
  logic [C_FRAMES_CNT_WIDTH-1:0] frame_cnt, frame_cnt_inc;

  logic                     push_q;
  logic [G_FRAME_WIDTH-1:0] push_data_q;
  logic [G_FRAME_WIDTH-1:0] mem [G_FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     full, pop_ok, push_ok, ovf_set;
  t_ch_status               status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {C_SYNC_STAGES{CPOL_L}};
      mosi_sync <= '0;
      load_sync <= '1;
      sclk_prev <= CPOL_L;
      load_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[C_SYNC_STAGES-2:0], i_spi_sclk};
      mosi_sync <= {mosi_sync[C_SYNC_STAGES-2:0], i_spi_mosi};
      load_sync <= {load_sync[C_SYNC_STAGES-2:0], i_spi_load};
      sclk_prev <= sclk_sync[C_SYNC_STAGES-1];
      load_prev <= load_sync[C_SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[C_SYNC_STAGES-1];
    mosi_s      = mosi_sync[C_SYNC_STAGES-1];
    load_s      = load_sync[C_SYNC_STAGES-1];
    sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);
    load_fall   = load_prev & ~load_s;
    load_rise   = ~load_prev & load_s;
    // A window opening on the same cycle as a sample edge restarts the frame.
    shift_en    = sample_edge & ~load_s & ~load_fall;
    frame_done  = shift_en && (bit_cnt == CNT_W'(G_FRAME_WIDTH - 1));
    len_err_set = load_rise && (bit_cnt != '0);
    shift_nxt   = (G_MSB_FIRST != 0) ? {shift_reg[G_FRAME_WIDTH-2:0], mosi_s}
                                     : {mosi_s, shift_reg[G_FRAME_WIDTH-1:1]};
    frame_cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg        <= '0;
      bit_cnt          <= '0;
      frame_cnt        <= '0;
      o_last_data      <= '0;
      o_frames_in_load <= '0;
      o_frame_received <= 1'b0;
      o_load_received  <= 1'b0;
      push_q           <= 1'b0;
      push_data_q      <= '0;
    end else begin
      o_frame_received <= frame_done;
      o_load_received  <= load_rise;
      push_q           <= frame_done;
      if (frame_done) push_data_q <= shift_nxt;
      if (load_fall) begin
        bit_cnt   <= '0;
        frame_cnt <= '0;
      end else if (load_rise) begin
        bit_cnt          <= '0;
        o_frames_in_load <= frame_done ? frame_cnt_inc : frame_cnt;
      end else if (shift_en) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= frame_done ? '0 : bit_cnt + 1'b1;
        if (frame_done) begin
          o_last_data <= shift_nxt;
          frame_cnt   <= frame_cnt_inc;
        end
      end
    end
  end

  // Pop handshake: a pop is accepted only when i_pop && o_fifo_valid; a pop
  // on an empty FIFO is a no-op. A push into a full FIFO succeeds only if a
  // pop is accepted in the same cycle, otherwise the frame is dropped.
  always_comb begin
    full    = (count == (AW+1)'(G_FIFO_DEPTH));
    pop_ok  = i_pop && (count != '0);
    push_ok = push_q && (!full || pop_ok);
    ovf_set = push_q && full && !pop_ok;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      status_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      status_q.overflow <= ovf_set | (status_q.overflow & ~i_clr_status);
      status_q.len_err  <= len_err_set | (status_q.len_err & ~i_clr_status);
    end
  end

  assign o_fifo_valid = (count != '0);
  assign o_fifo_data  = o_fifo_valid ? mem[rd_ptr] : '0;
  assign o_overflow   = status_q.overflow;
  assign o_len_err    = status_q.len_err;

endmodule

// File: rtl/spi_frame_collector.sv
// Multi-channel SPI frame collector: independent channel instances with
// their per-channel outputs flattened onto wide buses.
module spi_frame_collector
  import spi_frame_collector_pkg::*;
#(
  parameter int G_NB_CH       = 1,
  parameter int G_FRAME_WIDTH = 16,
  parameter int G_FIFO_DEPTH  = 8,
  parameter int G_CPOL        = 0,
  parameter int G_CPHA        = 0,
  parameter int G_MSB_FIRST   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [G_NB_CH-1:0]                    i_spi_sclk,
  input  logic [G_NB_CH-1:0]                    i_spi_mosi,
  input  logic [G_NB_CH-1:0]                    i_spi_load,
  input  logic [G_NB_CH-1:0]                    i_pop,
  input  logic [G_NB_CH-1:0]                    i_clr_status,
  output logic [G_NB_CH-1:0]                    o_frame_received,
  output logic [G_NB_CH-1:0]                    o_load_received,
  output logic [G_NB_CH*G_FRAME_WIDTH-1:0]      o_last_data,
  output logic [G_NB_CH*C_FRAMES_CNT_WIDTH-1:0] o_frames_in_load,
  output logic [G_NB_CH-1:0]                    o_fifo_valid,
  output logic [G_NB_CH*G_FRAME_WIDTH-1:0]      o_fifo_data,
  output logic [G_NB_CH-1:0]                    o_overflow,
  output logic [G_NB_CH-1:0]                    o_len_err
);

  for (genvar c = 0; c < G_NB_CH; c++) begin : g_ch
    spi_frame_collector_ch #(
      .G_FRAME_WIDTH (G_FRAME_WIDTH),
      .G_FIFO_DEPTH  (G_FIFO_DEPTH),
      .G_CPOL        (G_CPOL),
      .G_CPHA        (G_CPHA),
      .G_MSB_FIRST   (G_MSB_FIRST)
    ) u_ch (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_spi_sclk       (i_spi_sclk[c]),
      .i_spi_mosi       (i_spi_mosi[c]),
      .i_spi_load       (i_spi_load[c]),
      .i_pop            (i_pop[c]),
      .i_clr_status     (i_clr_status[c]),
      .o_frame_received (o_frame_received[c]),
      .o_load_received  (o_load_received[c]),
      .o_last_data      (o_last_data[c*G_FRAME_WIDTH +: G_FRAME_WIDTH]),
      .o_frames_in_load (o_frames_in_load[c*C_FRAMES_CNT_WIDTH +: C_FRAMES_CNT_WIDTH]),
      .o_fifo_valid     (o_fifo_valid[c]),
      .o_fifo_data      (o_fifo_data[c*G_FRAME_WIDTH +: G_FRAME_WIDTH]),
      .o_overflow       (o_overflow[c]),
      .o_len_err        (o_len_err[c])
    );
  end

endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed bench: a 1-channel mode-0 MSB-first collector and a 2-channel
// mode-3 LSB-first collector, checked against hand-computed values.
module tb_spi_frame_collector;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: 1 channel, mode 0, MSB first ----------------
  logic        sclk0 = 1'b0, mosi0 = 1'b0, load0 = 1'b1, pop0 = 1'b0, clr0 = 1'b0;
  logic        frame0, loadp0, valid0, ovf0, lerr0;
  logic [15:0] last0, fdata0;
  logic [7:0]  fil0;

  spi_frame_collector #(
    .G_NB_CH(1), .G_FRAME_WIDTH(16), .G_FIFO_DEPTH(8),
    .G_CPOL(0), .G_CPHA(0), .G_MSB_FIRST(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_spi_sclk(sclk0), .i_spi_mosi(mosi0), .i_spi_load(load0),
    .i_pop(pop0), .i_clr_status(clr0),
    .o_frame_received(frame0), .o_load_received(loadp0),
    .o_last_data(last0), .o_frames_in_load(fil0),
    .o_fifo_valid(valid0), .o_fifo_data(fdata0),
    .o_overflow(ovf0), .o_len_err(lerr0)
  );

  // ---------------- DUT 1: 2 channels, mode 3, LSB first ----------------
  logic [1:0]  sclk1 = 2'b11, mosi1 = 2'b00, load1 = 2'b11, pop1 = 2'b00, clr1 = 2'b00;
  logic [1:0]  frame1, loadp1, valid1, ovf1, lerr1;
  logic [31:0] last1, fdata1;
  logic [15:0] fil1;

  spi_frame_collector #(
    .G_NB_CH(2), .G_FRAME_WIDTH(16), .G_FIFO_DEPTH(8),
    .G_CPOL(1), .G_CPHA(1), .G_MSB_FIRST(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_spi_sclk(sclk1), .i_spi_mosi(mosi1), .i_spi_load(load1),
    .i_pop(pop1), .i_clr_status(clr1),
    .o_frame_received(frame1), .o_load_received(loadp1),
    .o_last_data(last1), .o_frames_in_load(fil1),
    .o_fifo_valid(valid1), .o_fifo_data(fdata1),
    .o_overflow(ovf1), .o_len_err(lerr1)
  );

  // ---------------- event counters ----------------
  int nfrm0 = 0, nload0 = 0, nfrm1a = 0, nfrm1b = 0;
  always @(posedge clk) begin
    if (frame0)    nfrm0  <= nfrm0 + 1;
    if (loadp0)    nload0 <= nload0 + 1;
    if (frame1[0]) nfrm1a <= nfrm1a + 1;
    if (frame1[1]) nfrm1b <= nfrm1b + 1;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0, MSB first; optionally pop exactly when the last bit's push lands.
  task automatic send0(input logic [15:0] d, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      mosi0 = d[15-i];
      wait_clk(4);
      sclk0 = 1'b1;
      if (pop_last && i == nbits - 1) begin
        wait_clk(3);
        pop0 = 1'b1;
        wait_clk(1);
        pop0 = 1'b0;
      end else begin
        wait_clk(4);
      end
      sclk0 = 1'b0;
    end
  endtask

  task automatic open0();
    load0 = 1'b0;
    wait_clk(4);
  endtask

  task automatic close0();
    wait_clk(4);
    load0 = 1'b1;
    wait_clk(6);
  endtask

  task automatic pop_chk0(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
    check({tag, "_valid"}, valid0, 1);
    check({tag, "_data"}, fdata0, e);
    pop0 = 1'b1;
    wait_clk(1);
    pop0 = 1'b0;
    wait_clk(1);
  endtask

  // Mode 3, LSB first; the enabled channels toggle two clocks apart.
  task automatic send1(input logic [1:0] en, input logic [15:0] d0, input logic [15:0] d1);
    load1 = ~en;
    wait_clk(4);
    for (int i = 0; i < 16; i++) begin
      if (en[0]) begin sclk1[0] = 1'b0; mosi1[0] = d0[i]; end
      wait_clk(2);
      if (en[1]) begin sclk1[1] = 1'b0; mosi1[1] = d1[i]; end
      wait_clk(2);
      if (en[0]) sclk1[0] = 1'b1;
      wait_clk(2);
      if (en[1]) sclk1[1] = 1'b1;
      wait_clk(2);
    end
    wait_clk(4);
    load1 = 2'b11;
    wait_clk(6);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int f0, l0, fa, fb;

    // reset state
    wait_clk(3);
    check("rst_frame_pulse", frame0, 0);
    check("rst_load_pulse", loadp0, 0);
    check("rst_last_data", last0, 0);
    check("rst_frames_in_load", fil0, 0);
    check("rst_fifo_valid", valid0, 0);
    check("rst_fifo_data", fdata0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_len_err", lerr0, 0);
    check("rst_dut1_last", last1, 0);
    rst_n = 1'b1;
    wait_clk(3);

    // single 16-bit frame
    f0 = nfrm0; l0 = nload0;
    open0();
    send0(16'h0C01, 16, 0);
    close0();
    exp_q.push_back(16'h0C01);
    check("single_frame_pulses", nfrm0 - f0, 1);
    check("single_load_pulses", nload0 - l0, 1);
    check("single_last_data", last0, 16'h0C01);
    check("single_frames_in_load", fil0, 1);
    pop_chk0("single_pop");
    check("single_empty", valid0, 0);

    // daisy chain of four frames in one window
    f0 = nfrm0;
    open0();
    for (int i = 1; i <= 4; i++) begin
      send0(16'h0101 * i[15:0], 16, 0);
      exp_q.push_back(16'h0101 * i[15:0]);
    end
    close0();
    check("daisy_frame_pulses", nfrm0 - f0, 4);
    check("daisy_frames_in_load", fil0, 4);
    check("daisy_last_data", last0, 16'h0404);
    for (int i = 0; i < 4; i++) pop_chk0("daisy_pop");
    check("daisy_empty", valid0, 0);

    // partial frame
    f0 = nfrm0;
    open0();
    send0(16'hFFC0, 10, 0);
    close0();
    check("partial_len_err", lerr0, 1);
    check("partial_no_frame", nfrm0 - f0, 0);
    check("partial_fifo_empty", valid0, 0);
    check("partial_frames_in_load", fil0, 0);
    check("partial_last_data_kept", last0, 16'h0404);
    clr0 = 1'b1; wait_clk(1); clr0 = 1'b0; wait_clk(1);
    check("partial_clr", lerr0, 0);

    // overflow: nine frames into an eight-deep FIFO
    f0 = nfrm0;
    open0();
    for (int i = 0; i < 9; i++) begin
      send0(16'h1000 + i[15:0], 16, 0);
      if (i < 8) exp_q.push_back(16'h1000 + i[15:0]);
    end
    close0();
    check("ovf_frame_pulses", nfrm0 - f0, 9);
    check("ovf_frames_in_load", fil0, 9);
    check("ovf_flag", ovf0, 1);
    check("ovf_last_data", last0, 16'h1008);
    check("ovf_head", fdata0, 16'h1000);
    clr0 = 1'b1; wait_clk(1); clr0 = 1'b0; wait_clk(1);
    check("ovf_clr", ovf0, 0);

    // push and pop in the same cycle on a full FIFO
    open0();
    send0(16'hABCD, 16, 1);
    close0();
    void'(exp_q.pop_front());
    exp_q.push_back(16'hABCD);
    check("pushpop_no_ovf", ovf0, 0);
    check("pushpop_last_data", last0, 16'hABCD);
    for (int i = 0; i < 8; i++) pop_chk0("pushpop_pop");
    check("pushpop_empty", valid0, 0);

    // reset mid-frame with a frame still queued
    open0();
    send0(16'h1111, 16, 0);
    send0(16'h7F00, 7, 0);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_last_data", last0, 0);
    check("midrst_fifo_valid", valid0, 0);
    check("midrst_fifo_data", fdata0, 0);
    check("midrst_frames_in_load", fil0, 0);
    load0 = 1'b1; sclk0 = 1'b0; mosi0 = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    exp_q.delete();
    wait_clk(4);
    check("postrst_len_err", lerr0, 0);
    check("postrst_fifo_valid", valid0, 0);
    f0 = nfrm0;
    open0();
    send0(16'h5A5A, 16, 0);
    close0();
    exp_q.push_back(16'h5A5A);
    check("postrst_frame_pulses", nfrm0 - f0, 1);
    check("postrst_last_data", last0, 16'h5A5A);
    check("postrst_len_err_after", lerr0, 0);
    pop_chk0("postrst_pop");

    // two channels, mode 3, LSB first, interleaved
    fa = nfrm1a; fb = nfrm1b;
    send1(2'b11, 16'h1234, 16'hBEEF);
    check("ch2_pulses_ch0", nfrm1a - fa, 1);
    check("ch2_pulses_ch1", nfrm1b - fb, 1);
    check("ch2_last_data", last1, 32'hBEEF_1234);
    check("ch2_frames_in_load", fil1, 16'h0101);
    check("ch2_fifo_valid", valid1, 2'b11);
    check("ch2_fifo_data", fdata1, 32'hBEEF_1234);
    fa = nfrm1a; fb = nfrm1b;
    send1(2'b10, 16'h0000, 16'h0F0F);
    check("ch1only_pulses_ch0", nfrm1a - fa, 0);
    check("ch1only_pulses_ch1", nfrm1b - fb, 1);
    check("ch1only_last_data", last1, 32'h0F0F_1234);
    check("ch1only_fifo_head", fdata1, 32'hBEEF_1234);
    check("ch1only_status", {ovf1, lerr1}, 4'b0000);
    pop1 = 2'b10; wait_clk(1); pop1 = 2'b00; wait_clk(1);
    check("ch1only_pop_ch1", fdata1, 32'h0F0F_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_collector.md
# spi_frame_collector

Parametrised, multi-channel SPI frame monitor for the testbench library, generalising the single-channel MAX7219 checker (fixed 16-bit frame, one load pulse, no buffering). Each channel oversamples SCLK/MOSI/LOAD with `clk`, deserialises frames of configurable width and SPI mode, and supports daisy-chained frames within one LOAD window. Each channel buffers its frames in its own FIFO. The block exposes per-channel event pulses for wait_event aliases, and data and status for check_level aliases.

## Interface
- G_NB_CH, 1: number of independent SPI channels.
- G_FRAME_WIDTH, 16: bits per frame (2..64).
- G_FIFO_DEPTH, 8: frames buffered per channel; power of 2, at least 2.
- G_CPOL, 0: SCLK idle level.
- G_CPHA, 0: sample edge. The sample edge is rising when G_CPOL==G_CPHA, otherwise falling.
- G_MSB_FIRST, 1: 1 means the first bit lands in the MSB.

- clk  in  1  system clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_spi_sclk  in  G_NB_CH  SPI clock per channel (asynchronous to clk).
- i_spi_mosi  in  G_NB_CH  SPI data per channel.
- i_spi_load  in  G_NB_CH  LOAD/CS per channel, active low; rising edge latches.
- i_pop  in  G_NB_CH  pop the head of the channel FIFO.
- i_clr_status  in  G_NB_CH  clear the sticky flags of the channel.
- o_frame_received  out  G_NB_CH  1-cycle pulse when a frame completes.
- o_load_received  out  G_NB_CH  1-cycle pulse on a LOAD rising edge.
- o_last_data  out  G_NB_CH*G_FRAME_WIDTH  last completed frame; channel c occupies slice [c*W +: W].
- o_frames_in_load  out  G_NB_CH*8  frames counted in the last LOAD window; saturates at 255.
- o_fifo_valid  out  G_NB_CH  FIFO not empty.
- o_fifo_data  out  G_NB_CH*G_FRAME_WIDTH  FIFO head, show-ahead.
- o_overflow  out  G_NB_CH  sticky: a frame was dropped on a full FIFO.
- o_len_err  out  G_NB_CH  sticky: LOAD rose with a partial frame.

## Operation
- Each of SCLK, MOSI and LOAD passes through a 2-FF synchroniser. A third register holds the previous synced value for edge detection.
- Bits shift only while synced LOAD is 0. A sample edge with LOAD high is ignored.
- Bit counter counts 0..W-1. On the sample edge with counter==W-1:
  - frame complete: o_last_data updates, o_frame_received pulses, push to the FIFO;
  - counter wraps to 0, which supports daisy chains;
  - frame counter increments, saturating.
- LOAD falling edge: clear the bit counter and the frame counter.
- LOAD rising edge:
  - o_load_received pulses;
  - o_frames_in_load takes the frame count, including a frame completing on the same cycle;
  - if counter != 0 (partial frame), set o_len_err and discard the partial bits;
  - counter cleared.
- FIFO push while full: frame dropped, o_overflow set. o_frame_received and o_last_data still update.
- FIFO push and i_pop in the same cycle while full: both accepted, no overflow.
- i_pop while empty: ignored.
- i_clr_status clears o_overflow and o_len_err. If a set condition occurs in the same cycle, set wins.
- Channels are fully independent; there is no shared state.

## Timing
- Reset values:
  - all pulses 0;
  - o_last_data 0;
  - o_frames_in_load 0;
  - o_fifo_valid 0;
  - o_fifo_data 0;
  - sticky flags 0;
  - synchronisers reset to G_CPOL for SCLK, 1 for LOAD, 0 for MOSI.
- Latency: a pin edge first captured at clk edge t0 is detected at edge t2. Shift, counter, pulses and o_last_data are visible after t2, i.e. 3 clk edges.
- Push at t2 makes o_fifo_valid/o_fifo_data valid after t3.
- Pop at edge tp advances o_fifo_data after tp.
- Minimum SCLK half-period: 3 clk periods. LOAD must stay low at least 3 clk periods.
- Reset mid-frame: all state cleared immediately, including FIFO contents. The first frame after reset starts at the next LOAD falling edge.

## Structure
- Package spi_frame_collector_pkg holds:
  - C_SYNC_STAGES = 2;
  - C_FRAMES_CNT_WIDTH = 8;
  - a clog2 function;
  - typedef t_ch_status {overflow, len_err}.
- Sub-module spi_frame_collector_ch holds one channel: synchroniser, deserialiser, counters, FIFO.
- The top only generate-loops G_NB_CH instances and flattens the buses.

## Test plan
- W=16, mode 0: LOAD low, shift 0x0C01 MSB-first, LOAD high -> one o_frame_received, o_last_data=0x0C01, o_load_received, o_frames_in_load=1, FIFO head 0x0C01.
- Daisy chain: 4 frames 0x0101, 0x0202, 0x0303, 0x0404 in one LOAD window -> 4 frame pulses, o_frames_in_load=4, pops return them in order.
- Partial frame: 10 bits then LOAD high -> o_len_err=1, no frame pulse, FIFO unchanged; i_clr_status clears the flag.
- Overflow with G_FIFO_DEPTH=8: push 9 frames without pop -> o_overflow=1, first 8 kept. Then pop and push in the same cycle while full -> no new overflow.
- Mode 3, LSB-first, G_NB_CH=2: interleaved traffic on both channels -> each channel reports only its own frames, values correct.
- rst_n low mid-frame after 7 bits -> all outputs return to reset values; next full frame is received correctly.
